mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Main control unit for the multi-cycle MIPS core. A Moore-style FSM sequences fetch, decode, execute, memory and writeback for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. It drives every datapath enable and mux select, and decodes ALU control from funct. Memory steps wait on a ready handshake and can be bounded by an optional timeout.

Parameters:
MAX_WAIT, 0, maximum cycles spent in a memory-wait state; 0 disables the timeout
WAIT_W, 8, width of the wait counter; MAX_WAIT must be < 2**WAIT_W

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  instr[31:26] from IR, stable from DECODE to end of instruction
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pcen  out  1  PC write enable = pcwrite | (branch & zero)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  data memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
zeroext  out  1  immediate zero-extend select
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
illegal_op  out  1  one-cycle pulse on an unsupported op or funct
mem_timeout  out  1  one-cycle pulse when a wait is aborted
state  out  4  current state, for debug

Behaviour:
- Reset low: state = FETCH immediately. All enables and strobes (pcen, memwrite, irwrite, regwrite) and all pulses are forced 0. Release is synchronous to the next clk edge.
- Default output values unless listed for a state: all 0, alucontrol = 010.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ORIEX 12, ORIWB 13.
- FETCH: alusrcb = 01, add. irwrite = pcwrite = mem_ready. Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE: alusrcb = 11, add. Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH, with illegal_op = 1 this cycle
- MEMADR: alusrca = 1, alusrcb = 10, add. Goes to MEMRD if lw, MEMWR if sw.
- MEMRD: iord = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1, instr_done = 1, then FETCH.
- MEMWR: iord = 1, memwrite = 1 held while waiting. instr_done = mem_ready. Goes to FETCH on mem_ready.
- RTYPEEX: alusrca = 1, alusrcb = 00, alucontrol from funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111
  - any other funct → illegal_op = 1, next FETCH, no writeback
- RTYPEWB: regdst = 1, regwrite = 1, instr_done = 1, then FETCH.
- BEQEX: alusrca = 1, sub, branch = 1, pcsrc = 01, instr_done = 1, then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, add, then ADDIWB.
- ADDIWB: regwrite = 1, instr_done = 1, then FETCH.
- JEX: pcsrc = 10, pcwrite = 1, instr_done = 1, then FETCH.
- Latency with mem_ready held 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR; increments each cycle while mem_ready = 0.
  - If MAX_WAIT != 0 and the count reaches MAX_WAIT with mem_ready = 0: mem_timeout = 1, write strobes are deasserted that cycle, next state FETCH, PC unchanged.
  - mem_ready = 1 in the same cycle as the limit is reached: completion wins and there is no timeout.
  - MAX_WAIT = 0: waits indefinitely.
- Reset asserted mid-instruction: abort immediately; no partial writeback occurs after reset deasserts.

Optional Feature:
MC_ORI_EN
- Defined: op 001101 in DECODE goes to ORIEX.
  - ORIEX: alusrca = 1, alusrcb = 10, or, zeroext = 1.
  - ORIWB: regwrite = 1, zeroext = 1, instr_done = 1, then FETCH.
  - Latency 4 cycles.
- Undefined: op 001101 is illegal; zeroext is tied 0; states 12 and 13 are unreachable.

Test Plan:
- Reset low for 1 ns, then add $t2,$t0,$t1 with mem_ready = 1 → state sequence 0,1,6,7,0; alucontrol 010 in cycle 3; regwrite and regdst = 1 in cycle 4; instr_done in cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with memtoreg = regwrite = 1; total 8 cycles.
- beq with zero = 1, then with zero = 0 → pcen = 1 in BEQEX only when zero = 1; 3 cycles each; pcsrc = 01.
- op 111111 in DECODE → illegal_op pulse, back to FETCH, no regwrite or memwrite asserted.
- MAX_WAIT = 4, sw with mem_ready stuck 0 → memwrite high 4 cycles, mem_timeout pulse, FETCH next, pcen never asserted during the abort.
- reset pulled low in RTYPEWB → state 0 asynchronously, regwrite = 0 within the same cycle; ori with MC_ORI_EN → zeroext = 1 and alucontrol 001, 4 cycles; without the macro → illegal_op pulse.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main control unit.
// Moore-style sequencer for lw, sw, R-type, beq, addi and j, with ALU control
// decoded from funct and a bounded wait on the memory ready handshake.
// Optional build macro: MC_ORI_EN adds the ori instruction (states 12/13).
module mc_control_fsm #(
    parameter int MAX_WAIT = 0,   // 0 = wait for mem_ready indefinitely
    parameter int WAIT_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pcen_o,
    output logic       iord_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       regwrite_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic       zeroext_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic       mem_timeout_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
        BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX    = 4'd11,
        ORIEX   = 4'd12, ORIWB   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ORI_EN
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic pcwrite, branch, irwrite, memwrite, regwrite, instr_done, illegal_op;
    logic mem_timeout, limit_hit;

    // State register and wait counter; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, datapath controls and wait-counter update.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite      = 1'b0;
        memwrite     = 1'b0;
        regwrite     = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        mem_timeout  = 1'b0;
        iord_o       = 1'b0;
        regdst_o     = 1'b0;
        memtoreg_o   = 1'b0;
        alusrca_o    = 1'b0;
        alusrcb_o    = 2'b00;
        pcsrc_o      = 2'b00;
        alucontrol_o = ALU_ADD;
        zeroext_o    = 1'b0;
        // Only the memory states ever evaluate this; a late ready still wins.
        limit_hit    = (MAX_WAIT != 0) && (wait_q == MAX_WAIT_C) && !mem_ready_i;

        case (state_q)
            FETCH: begin
                alusrcb_o = 2'b01;
                if (limit_hit) begin
                    mem_timeout = 1'b1;
                end else begin
                    irwrite = mem_ready_i;
                    pcwrite = mem_ready_i;
                    if (mem_ready_i) state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb_o = 2'b11;
                case (op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_ORI_EN
                    OP_ORI:       state_d = ORIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                state_d   = (op_i == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord_o = 1'b1;
                if (limit_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = FETCH;
                end else if (mem_ready_i) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                memtoreg_o = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_o = 1'b1;
                if (limit_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = FETCH;
                end else begin
                    memwrite   = 1'b1;
                    instr_done = mem_ready_i;
                    if (mem_ready_i) state_d = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca_o = 1'b1;
                state_d   = RTYPEWB;
                case (funct_i)
                    6'b100000: alucontrol_o = ALU_ADD;
                    6'b100010: alucontrol_o = ALU_SUB;
                    6'b100100: alucontrol_o = ALU_AND;
                    6'b100101: alucontrol_o = ALU_OR;
                    6'b101010: alucontrol_o = ALU_SLT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regdst_o   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BEQEX: begin
                alusrca_o    = 1'b1;
                alucontrol_o = ALU_SUB;
                branch       = 1'b1;
                pcsrc_o      = 2'b01;
                instr_done   = 1'b1;
                state_d      = FETCH;
            end
            ADDIEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JEX: begin
                pcsrc_o    = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef MC_ORI_EN
            ORIEX: begin
                alusrca_o    = 1'b1;
                alusrcb_o    = 2'b10;
                alucontrol_o = ALU_OR;
                zeroext_o    = 1'b1;
                state_d      = ORIWB;
            end
            ORIWB: begin
                regwrite   = 1'b1;
                zeroext_o  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Counter restarts whenever a state is (re)entered, saturates otherwise.
        if ((state_d != state_q) || mem_timeout) begin
            wait_d = '0;
        end else if (!mem_ready_i && (wait_q != {WAIT_W{1'b1}})) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Strobes and pulses are held low for as long as reset is asserted.
    assign pcen_o        = rst_ni & (pcwrite | (branch & zero_i));
    assign irwrite_o     = rst_ni & irwrite;
    assign memwrite_o    = rst_ni & memwrite;
    assign regwrite_o    = rst_ni & regwrite;
    assign instr_done_o  = rst_ni & instr_done;
    assign illegal_op_o  = rst_ni & illegal_op;
    assign mem_timeout_o = rst_ni & mem_timeout;
    assign state_o       = state_q;

endmodule
